// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC sequencer: FSM states, reset/exception vectors, fetch stride.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    HOLD     = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;
  localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/pc_next_calc.sv
// Redirect resolution: flags any pending redirect and selects its target
// with priority Exception > Jump > Branch. Purely combinational.
module pc_next_calc
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF)
) (
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_base,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic              exception,
  output logic              redirect,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] exc_addr;

  // Offset is in words: sign-extend, then scale by 4 via the appended zeros.
  assign branch_addr = branch_base + {{(ADDR_W-18){branch_offset[15]}}, branch_offset, 2'b00};
  assign jump_addr   = {branch_base[ADDR_W-1:28], jump_target, 2'b00};
  assign exc_addr    = {EXC_VECTOR[ADDR_W-1:2], 2'b00};

  assign redirect = exception | jump | branch_taken;

  always_comb begin
    target = branch_addr;
    if (exception) begin
      target = exc_addr;
    end else if (jump) begin
      target = jump_addr;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: chooses the next PC, runs the I-mem
// request/ready handshake and raises Flush while a redirect is in progress.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(EXC_VECTOR_DEF)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchBase,
  input  logic [15:0]       BranchOffset,
  input  logic              Jump,
  input  logic [25:0]       JumpTarget,
  input  logic              Exception,
  input  logic              InsReady,
  output logic              InsReq,
  output logic [ADDR_W-1:0] InsAddress,
  output logic              InsValid,
  output logic              Flush,
  output logic [ADDR_W-1:0] EpcOut
);

  localparam logic [ADDR_W-1:0] RESET_PC = {RESET_VECTOR[ADDR_W-1:2], 2'b00};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, epc;
  logic [ADDR_W-1:0] redir_target;
  logic              redir;
  logic              valid, valid_nxt;
  logic              exc_take;

  pc_next_calc #(
    .ADDR_W     (ADDR_W),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next (
    .branch_taken  (BranchTaken),
    .branch_base   (BranchBase),
    .branch_offset (BranchOffset),
    .jump          (Jump),
    .jump_target   (JumpTarget),
    .exception     (Exception),
    .redirect      (redir),
    .target        (redir_target)
  );

  // BOOT ignores redirects, so the EPC only captures once the core is live.
  assign exc_take = Exception && (state != BOOT);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = 1'b0;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        if (redir) begin
          state_nxt = REDIRECT;
          pc_nxt    = redir_target;
        end else if (InsReady) begin
          pc_nxt    = pc + ADDR_W'(PC_INC);
          valid_nxt = 1'b1;
          state_nxt = Stall ? HOLD : FETCH;
        end
      end
      HOLD: begin
        if (redir) begin
          state_nxt = REDIRECT;
          pc_nxt    = redir_target;
        end else if (!Stall) begin
          state_nxt = FETCH;
        end
      end
      REDIRECT: begin
        if (redir) begin
          pc_nxt = redir_target;
        end else begin
          state_nxt = Stall ? HOLD : FETCH;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= BOOT;
      pc    <= RESET_PC;
      valid <= 1'b0;
      epc   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      valid <= valid_nxt;
      if (exc_take) begin
        epc <= pc;
      end
    end
  end

  assign InsReq     = (state == FETCH);
  assign Flush      = (state == REDIRECT);
  assign InsAddress = pc;
  assign InsValid   = valid;
  assign EpcOut     = epc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed test-plan walk plus randomized traffic, scored against a cycle-level reference model.
module tb_pc_sequencer;

  logic        CLK = 1'b1;
  logic        RST, Stall, BranchTaken, Jump, Exception, InsReady;
  logic [31:0] BranchBase;
  logic [15:0] BranchOffset;
  logic [25:0] JumpTarget;
  logic        InsReq, InsValid, Flush;
  logic [31:0] InsAddress, EpcOut;

  always #5 CLK = ~CLK;

  pc_sequencer dut (
    .CLK          (CLK),
    .RST          (RST),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchBase   (BranchBase),
    .BranchOffset (BranchOffset),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Exception    (Exception),
    .InsReady     (InsReady),
    .InsReq       (InsReq),
    .InsAddress   (InsAddress),
    .InsValid     (InsValid),
    .Flush        (Flush),
    .EpcOut       (EpcOut)
  );

  typedef struct packed {
    logic        req;
    logic        valid;
    logic        flush;
    logic [31:0] addr;
    logic [31:0] epc;
  } out_t;

  typedef enum {M_BOOT, M_FETCH, M_HOLD, M_REDIR} mode_t;

  out_t        expq[$];
  logic [31:0] fetchq[$];
  mode_t       m_mode;
  logic [31:0] m_pc, m_epc;
  logic        m_valid;
  int          nchk = 0;
  int          nerr = 0;
  logic [31:0] last_addr = 32'h0;
  out_t        mon_act, mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_BOOT;
    m_pc    = 32'h0;
    m_epc   = 32'h0;
    m_valid = 1'b0;
    fetchq.delete();
  endtask

  task automatic model_step();
    logic        rd;
    logic [31:0] tgt;
    int          words;
    rd    = (m_mode != M_BOOT) && (Exception || Jump || BranchTaken);
    words = int'($signed(BranchOffset));
    if (Exception)  tgt = 32'h80;
    else if (Jump)  tgt = (BranchBase & 32'hF000_0000) | ({6'd0, JumpTarget} << 2);
    else            tgt = BranchBase + 32'(words * 4);
    if (Exception && m_mode != M_BOOT) m_epc = m_pc;
    m_valid = 1'b0;
    case (m_mode)
      M_BOOT: m_mode = M_FETCH;
      M_FETCH: begin
        if (rd) begin
          m_mode = M_REDIR;
          m_pc   = tgt;
        end else if (InsReady) begin
          fetchq.push_back(m_pc);
          m_pc    = m_pc + 32'd4;
          m_valid = 1'b1;
          m_mode  = Stall ? M_HOLD : M_FETCH;
        end
      end
      M_HOLD: begin
        if (rd) begin
          m_mode = M_REDIR;
          m_pc   = tgt;
        end else if (!Stall) m_mode = M_FETCH;
      end
      default: begin
        if (rd) m_pc = tgt;
        else    m_mode = Stall ? M_HOLD : M_FETCH;
      end
    endcase
  endtask

  // Record what this cycle must show, advance the model, then move to just past the next edge.
  task automatic tick();
    out_t o;
    if (RST) model_reset();
    o.req   = (m_mode == M_FETCH);
    o.valid = m_valid;
    o.flush = (m_mode == M_REDIR);
    o.addr  = m_pc;
    o.epc   = m_epc;
    expq.push_back(o);
    if (!RST) model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    Stall        = 1'b0;
    BranchTaken  = 1'b0;
    Jump         = 1'b0;
    Exception    = 1'b0;
    InsReady     = 1'b1;
    BranchBase   = 32'h0;
    BranchOffset = 16'h0;
    JumpTarget   = 26'h0;
  endtask

  always @(negedge CLK) begin
    mon_act = '{InsReq, InsValid, Flush, InsAddress, EpcOut};
    if (expq.size() > 0) begin
      mon_exp = expq.pop_front();
      nchk++;
      if (mon_act !== mon_exp) begin
        nerr++;
        $display("FAIL outputs @%0t: got req=%b vld=%b flush=%b addr=%h epc=%h expected req=%b vld=%b flush=%b addr=%h epc=%h",
                 $time, mon_act.req, mon_act.valid, mon_act.flush, mon_act.addr, mon_act.epc,
                 mon_exp.req, mon_exp.valid, mon_exp.flush, mon_exp.addr, mon_exp.epc);
      end
    end
    if (InsValid === 1'b1) begin
      if (fetchq.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL fetch_unexpected @%0t: got InsValid=1 expected no completion", $time);
      end else begin
        chk("fetch_addr", last_addr, fetchq.pop_front());
      end
    end
    last_addr = InsAddress;
  end

  initial begin
    quiet();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    chk("boot_req", 32'(InsReq), 32'd0);
    chk("boot_addr", InsAddress, 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("stream_req", 32'(InsReq), 32'd1);
      chk("stream_addr", InsAddress, 32'(i * 4));
      tick();
    end
    chk("stream_vld", 32'(InsValid), 32'd1);
    InsReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_addr", InsAddress, 32'h8);
      chk("wait_req", 32'(InsReq), 32'd1);
      tick();
    end
    InsReady = 1'b1;
    tick();
    chk("wait_done_addr", InsAddress, 32'hC);
    chk("wait_done_vld", 32'(InsValid), 32'd1);
    tick();

    BranchTaken = 1'b1; BranchBase = 32'h10; BranchOffset = 16'hFFFE;
    tick();
    quiet();
    chk("br_flush", 32'(Flush), 32'd1);
    chk("br_target", InsAddress, 32'h8);
    chk("br_no_vld", 32'(InsValid), 32'd0);
    tick();
    chk("br_flush_end", 32'(Flush), 32'd0);
    chk("br_refetch", InsAddress, 32'h8);
    tick(); tick(); tick();

    Stall = 1'b1;
    chk("stall_accept_addr", InsAddress, 32'h14);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) Stall = 1'b0;
      chk("hold_req", 32'(InsReq), 32'd0);
      chk("hold_addr", InsAddress, 32'h18);
      tick();
    end
    chk("hold_release_req", 32'(InsReq), 32'd1);
    chk("hold_release_addr", InsAddress, 32'h18);
    Stall = 1'b1;
    tick();
    Jump = 1'b1; BranchBase = 32'h20; JumpTarget = 26'h9;
    tick();
    quiet();
    chk("hold_jump_flush", 32'(Flush), 32'd1);
    chk("hold_jump_addr", InsAddress, 32'h24);
    tick();

    Exception = 1'b1; Jump = 1'b1; JumpTarget = 26'h40;
    BranchTaken = 1'b1; BranchBase = 32'h28; BranchOffset = 16'h4;
    tick();
    quiet();
    chk("exc_addr", InsAddress, 32'h80);
    chk("exc_epc", EpcOut, 32'h24);
    chk("exc_flush", 32'(Flush), 32'd1);
    tick();
    chk("exc_flush_end", 32'(Flush), 32'd0);

    Jump = 1'b1; BranchBase = 32'hF000_0000; JumpTarget = 26'h3FF_FFFF;
    tick();
    quiet();
    chk("wrap_target", InsAddress, 32'hFFFF_FFFC);
    tick();
    tick();
    chk("wrap_addr", InsAddress, 32'h0);
    tick();
    InsReady = 1'b0;
    tick();
    RST = 1'b1;
    #1;
    chk("rst_addr", InsAddress, 32'h0);
    chk("rst_req", 32'(InsReq), 32'd0);
    chk("rst_vld", 32'(InsValid), 32'd0);
    chk("rst_flush", 32'(Flush), 32'd0);
    chk("rst_epc", EpcOut, 32'h0);
    tick();
    RST = 1'b0;
    quiet();

    for (int n = 0; n < 3000; n++) begin
      RST          = ($urandom_range(0, 299) == 0);
      Stall        = ($urandom_range(0, 3) == 0);
      InsReady     = ($urandom_range(0, 2) != 0);
      BranchTaken  = ($urandom_range(0, 9) == 0);
      Jump         = ($urandom_range(0, 15) == 0);
      Exception    = ($urandom_range(0, 23) == 0);
      BranchBase   = $urandom & 32'hFFFF_FFFC;
      BranchOffset = 16'($urandom);
      JumpTarget   = 26'($urandom);
      tick();
    end

    RST = 1'b0;
    quiet();
    InsReady = 1'b0;
    tick(); tick(); tick();
    @(negedge CLK);
    #1;
    chk("expq_drained", 32'(expq.size()), 32'd0);
    chk("fetchq_drained", 32'(fetchq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
